move_exec: RTL and testbench
============================

Name: move_exec

Overview:
- Move sequencer that sits directly upstream of the 64 per-square piece registers.
- Accepts one move request (from-square, to-square) over a valid/ready handshake and reads the current board contents.
- Drives the shared square write bus (one-hot enable plus 10-bit data): the moving piece is written into the destination square, then the source square is cleared.
- Reports completion, any captured piece, and rejection of illegal requests.

Parameters:
- SQUARES, 64, number of board squares (one piece register each)
- PW, 10, piece word width; value 0 means empty square
- IW, 6, square index width; clog2(SQUARES)

Ports:
- clk, input, 1, system clock; all state changes on rising edge
- rst, input, 1, asynchronous active-low reset
- req_valid, input, 1, move request present
- req_ready, output, 1, block can accept a request (high only in IDLE)
- req_from, input, IW, source square index
- req_to, input, IW, destination square index
- board, input, SQUARES*PW, flattened piece register outputs; square k occupies bits [k*PW +: PW]
- sq_en, output, SQUARES, one-hot write enable to the piece registers
- sq_data, output, PW, shared write data to the piece registers
- done, output, 1, one-cycle pulse when a request finishes (success or error)
- err, output, 1, valid with done; 1 means the request was rejected and the board is unchanged
- captured, output, PW, valid with done; prior destination contents (0 if the square was empty or on error)

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; req_ready=1; sq_en=0; sq_data=0; done=0; err=0; captured=0; internal from/to/piece latches=0.
- Reset mid-move: the move is abandoned immediately and no further enables are issued. A partially completed move is not rolled back; the board is reset by the same rst.
- FSM states: IDLE, FETCH, WRITE, CLEAR, FIN.
- IDLE: req_ready=1. On req_valid&&req_ready at an edge, latch req_from/req_to and go to FETCH. No other state accepts requests.
- FETCH (1 cycle):
  - Latch piece=board[from] and cap=board[to].
  - If from==to or piece==0: set err_r=1, cap_r=0, go to FIN.
  - Otherwise err_r=0, cap_r=board[to], go to WRITE.
- WRITE (1 cycle): sq_en has only bit [to] set; sq_data=piece. The destination register captures at the closing edge. Go to CLEAR.
- CLEAR (1 cycle): sq_en has only bit [from] set; sq_data=0. Go to FIN.
- FIN (1 cycle): done=1, err=err_r, captured=cap_r. Go to IDLE.
- Outputs done, err and captured are 0 outside FIN.
- sq_en is all-zero outside WRITE and CLEAR. sq_data is 0 outside WRITE.
- Outputs are decoded from the registered state and latches only; board changes during a move do not affect sq_data after FETCH.
- At most one bit of sq_en is ever high. sq_en is never high on the error path.
- Latency, legal move: acceptance edge to done high = 4 cycles (FETCH, WRITE, CLEAR, FIN). Back-to-back throughput is 1 move per 5 cycles, because IDLE lasts at least 1 cycle.
- Latency, error: done high 2 cycles after acceptance.
- Indices are IW bits. With SQUARES=64 every index is valid. If SQUARES < 2^IW, an index >= SQUARES is treated as an error in FETCH.
- req_from/req_to may change freely while not in IDLE; they are ignored.

Test Plan:
- Reset then idle: rst low for 2 cycles, release -> req_ready=1, sq_en=0, done=0 held for 10 cycles with req_valid=0.
- Quiet move: board[12]=10'h041, board[28]=0; request from=12, to=28 -> sq_en=1<<28 with sq_data=10'h041 at cycle 2 after accept; sq_en=1<<12 with sq_data=0 at cycle 3; done=1, err=0, captured=0 at cycle 4; afterwards board[28]=10'h041, board[12]=0.
- Capture: board[3]=10'h085, board[59]=10'h102; move 3->59 -> done with err=0, captured=10'h102; board[59]=10'h085, board[3]=0.
- Errors:
  - Empty source (board[7]=0), move 7->15 -> done at cycle 2, err=1, captured=0, sq_en never nonzero.
  - Move 20->20 with board[20]=10'h011 -> same error response.
- Handshake: hold req_valid high with changing indices throughout a move -> exactly one accept per move, only in IDLE. req_ready=0 for the 4 cycles after accept. The second request is accepted on the first IDLE edge.
- Reset mid-op: assert rst during WRITE of move 5->6 -> all outputs 0 asynchronously, state IDLE. After release, a new move 1->2 completes normally.

Source files
------------

// File: rtl/move_exec.sv
// rtl/move_exec.sv - move sequencer driving the per-square piece register write bus
// Accepts one (from, to) request, writes the piece to its destination, then clears the source.
module move_exec #(
   parameter int SQUARES = 64,
   parameter int PW      = 10,
   parameter int IW      = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [IW-1:0]         req_from,
   input  logic [IW-1:0]         req_to,
   input  logic [SQUARES*PW-1:0] board,
   output logic [SQUARES-1:0]    sq_en,
   output logic [PW-1:0]         sq_data,
   output logic                  done,
   output logic                  err,
   output logic [PW-1:0]         captured
);

   typedef enum logic [2:0] {IDLE, FETCH, WRITE, CLEAR, FIN} state_t;

   localparam logic [SQUARES-1:0] ONE = {{(SQUARES-1){1'b0}}, 1'b1};

   state_t        state;
   logic [IW-1:0] from_r;
   logic [IW-1:0] to_r;
   logic [PW-1:0] cap_r;
   logic          err_r;

   logic          idx_bad;
   logic [PW-1:0] piece_rd;
   logic [PW-1:0] cap_rd;

   // Out-of-range indices only exist when SQUARES is not a power of two.
   always_comb begin
      idx_bad  = (int'(from_r) >= SQUARES) || (int'(to_r) >= SQUARES);
      piece_rd = '0;
      cap_rd   = '0;
      if (!idx_bad) begin
         piece_rd = board[from_r*PW +: PW];
         cap_rd   = board[to_r*PW +: PW];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         sq_en     <= '0;
         sq_data   <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         captured  <= '0;
         from_r    <= '0;
         to_r      <= '0;
         cap_r     <= '0;
         err_r     <= 1'b0;
      end else begin
         sq_en    <= '0;
         sq_data  <= '0;
         done     <= 1'b0;
         err      <= 1'b0;
         captured <= '0;
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  from_r    <= req_from;
                  to_r      <= req_to;
                  req_ready <= 1'b0;
                  state     <= FETCH;
               end
            end
            FETCH: begin
               if (idx_bad || from_r == to_r || piece_rd == '0) begin
                  err_r    <= 1'b1;
                  cap_r    <= '0;
                  done     <= 1'b1;
                  err      <= 1'b1;
                  captured <= '0;
                  state    <= FIN;
               end else begin
                  // sq_data holds the fetched piece for the whole WRITE cycle.
                  err_r   <= 1'b0;
                  cap_r   <= cap_rd;
                  sq_en   <= ONE << to_r;
                  sq_data <= piece_rd;
                  state   <= WRITE;
               end
            end
            WRITE: begin
               sq_en <= ONE << from_r;
               state <= CLEAR;
            end
            CLEAR: begin
               done     <= 1'b1;
               err      <= err_r;
               captured <= cap_r;
               state    <= FIN;
            end
            FIN: begin
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               req_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_move_exec.sv
// tb/tb_move_exec.sv - randomized self-checking bench for move_exec
// Piece registers and a move-level reference board live in the bench.
module tb_move_exec;

   localparam int SQUARES = 64;
   localparam int PW      = 10;
   localparam int IW      = 6;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  req_valid;
   logic                  req_ready;
   logic [IW-1:0]         req_from;
   logic [IW-1:0]         req_to;
   logic [SQUARES*PW-1:0] board;
   logic [SQUARES-1:0]    sq_en;
   logic [PW-1:0]         sq_data;
   logic                  done;
   logic                  err;
   logic [PW-1:0]         captured;

   logic [PW-1:0] regs [SQUARES];
   logic [PW-1:0] mdl  [SQUARES];
   logic          pk_en;
   logic [IW-1:0] pk_idx;
   logic [PW-1:0] pk_val;

   int vectors = 0;
   int errors  = 0;
   int acc_cnt = 0;

   move_exec #(.SQUARES(SQUARES), .PW(PW), .IW(IW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_from(req_from), .req_to(req_to), .board(board), .sq_en(sq_en),
      .sq_data(sq_data), .done(done), .err(err), .captured(captured)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < SQUARES; k++) regs[k] <= '0;
      end else begin
         for (int k = 0; k < SQUARES; k++) if (sq_en[k]) regs[k] <= sq_data;
         if (pk_en) regs[pk_idx] <= pk_val;
      end
   end

   always_comb begin
      board = '0;
      for (int k = 0; k < SQUARES; k++) board[k*PW +: PW] = regs[k];
   end

   always @(posedge clk) if (rst && req_valid && req_ready) acc_cnt++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) if (rst) check("onehot", 64'($countones(sq_en) <= 1), 64'd1);

   task automatic poke(input int idx, input logic [PW-1:0] val);
      pk_en = 1'b1; pk_idx = IW'(idx); pk_val = val;
      @(negedge clk);
      pk_en = 1'b0;
      mdl[idx] = val;
   endtask

   task automatic do_move(input int f, input int t, input bit hold, input bit b2b);
      int waits = 0;
      int acc0;
      int last;
      bit legal;
      logic [PW-1:0] piece, cap;
      logic [63:0] exp_en;
      int other;
      req_valid = 1'b1; req_from = IW'(f); req_to = IW'(t);
      while (!req_ready && waits < 10) begin
         @(negedge clk);
         waits++;
      end
      if (b2b) check("b2b_wait", 64'(waits), 64'd1);
      else check("ready_idle", 64'(req_ready), 64'd1);
      acc0  = acc_cnt;
      legal = (f != t) && (mdl[f] != 0);
      piece = mdl[f];
      cap   = legal ? mdl[t] : '0;
      last  = legal ? 4 : 2;
      @(posedge clk);
      for (int c = 1; c <= last; c++) begin
         @(negedge clk);
         if (hold && c < last) begin
            req_from = IW'($urandom); req_to = IW'($urandom);
         end else begin
            req_valid = 1'b0;
         end
         exp_en = 64'd0;
         if (legal && c == 2) exp_en = 64'd1 << t;
         if (legal && c == 3) exp_en = 64'd1 << f;
         check("sq_en", sq_en, exp_en);
         check("sq_data", 64'(sq_data), (legal && c == 2) ? 64'(piece) : 64'd0);
         check("done", 64'(done), 64'(c == last));
         check("ready_busy", 64'(req_ready), 64'd0);
         if (c == last) begin
            check("err", 64'(err), 64'(!legal));
            check("captured", 64'(captured), 64'(cap));
         end else begin
            check("err_idle", 64'(err), 64'd0);
         end
      end
      check("accepts", 64'(acc_cnt - acc0), 64'd1);
      if (legal) begin
         mdl[t] = piece;
         mdl[f] = '0;
      end
      other = int'($urandom_range(SQUARES-1, 0));
      check("dst_sq", 64'(regs[t]), 64'(mdl[t]));
      check("src_sq", 64'(regs[f]), 64'(mdl[f]));
      check("other_sq", 64'(regs[other]), 64'(mdl[other]));
   endtask

   initial begin
      int f, t;
      rst = 1'b0; req_valid = 1'b0; req_from = '0; req_to = '0;
      pk_en = 1'b0; pk_idx = '0; pk_val = '0;
      for (int k = 0; k < SQUARES; k++) mdl[k] = '0;
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("rst_ready", 64'(req_ready), 64'd1);
         check("rst_sq_en", sq_en, 64'd0);
         check("rst_done", 64'(done), 64'd0);
      end
      check("rst_data", 64'(sq_data), 64'd0);
      check("rst_cap", 64'(captured), 64'd0);
      check("rst_err", 64'(err), 64'd0);

      poke(12, 10'h041); poke(28, 10'h000);
      do_move(12, 28, 1'b0, 1'b0);
      @(negedge clk);
      poke(3, 10'h085); poke(59, 10'h102);
      do_move(3, 59, 1'b0, 1'b0);
      @(negedge clk);
      poke(7, 10'h000);
      do_move(7, 15, 1'b0, 1'b0);
      @(negedge clk);
      poke(20, 10'h011);
      do_move(20, 20, 1'b0, 1'b0);
      @(negedge clk);
      poke(40, 10'h2a5); poke(41, 10'h133);
      do_move(40, 41, 1'b1, 1'b0);
      do_move(41, 42, 1'b0, 1'b1);

      // Reset lands while the destination enable is on the bus.
      @(negedge clk);
      poke(5, 10'h0c3); poke(6, 10'h001);
      req_valid = 1'b1; req_from = 6'd5; req_to = 6'd6;
      @(posedge clk);
      @(negedge clk); req_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_en", sq_en, 64'd1 << 6);
      rst = 1'b0;
      #1;
      check("arst_en", sq_en, 64'd0);
      check("arst_data", 64'(sq_data), 64'd0);
      check("arst_ready", 64'(req_ready), 64'd1);
      check("arst_done", 64'(done), 64'd0);
      for (int k = 0; k < SQUARES; k++) mdl[k] = '0;
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      poke(1, 10'h3ff);
      do_move(1, 2, 1'b0, 1'b0);

      for (int k = 0; k < SQUARES; k++)
         poke(k, ($urandom_range(1, 0) != 0) ? PW'($urandom) : '0);
      for (int i = 0; i < 60; i++) begin
         f = int'($urandom_range(SQUARES-1, 0));
         t = ($urandom_range(3, 0) == 0) ? f : int'($urandom_range(SQUARES-1, 0));
         do_move(f, t, ($urandom_range(1, 0) != 0), 1'b0);
         if ($urandom_range(1, 0) != 0) @(negedge clk);
         if ($urandom_range(3, 0) == 0) poke(int'($urandom_range(SQUARES-1, 0)), PW'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
